// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell; the only arithmetic in the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);

  assign s = a ^ b ^ cin;
  assign c = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell, LSB-first, one bit per clock in RUN.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; in_ready is high only in IDLE, out_valid only in DONE.

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_c;

  full_adder u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry),
    .s   (fa_s),
    .c   (fa_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)        state_nxt = RUN;
      RUN:     if (cnt == LAST_BIT) state_nxt = DONE;
      DONE:    if (out_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);

  // Registers only move on accept or in RUN, so results hold through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (state == IDLE && in_valid) begin
      a_sr  <= a;
      b_sr  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
      carry  <= fa_c;
      cnt    <= cnt + 1'b1;
    end
  end

  assign sum  = sum_sr;
  assign cout = carry;

`ifdef SERIAL_ADD_OVF_EN
  // Carry entering the MSB cell, captured while bit WIDTH-1 is processed.
  logic c_msb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                c_msb <= 1'b0;
    else if (state == RUN && cnt == LAST_BIT) c_msb <= carry;
  end

  assign ovf = c_msb ^ carry;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8); covers SERIAL_ADD_OVF_EN when defined.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  logic [W:0] exp_q[$];
  logic       ovf_q[$];
  int         checks;
  int         errors;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one operation, pushes its expected result, then waits for the
  // result and compares. Latency counts the accepting edge as edge 1.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc, input int stall, input bit toggle);
    logic [W:0]   res;
    logic [W-1:0] held_sum;
    logic         held_cout;
    int           k;
    int           busy_n;
    bit           got;
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    out_ready = (stall == 0);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    res = {1'b0, ta} + {1'b0, tb_v} + {{W{1'b0}}, tc};
    exp_q.push_back(res);
    ovf_q.push_back((ta[W-1] == tb_v[W-1]) && (res[W-1] != ta[W-1]));
    @(posedge clk);
    #1 in_valid = 1'b0;
    k = 0; busy_n = 0; got = 0;
    while (k < 4*W && !got) begin
      @(negedge clk);
      k++;
      if (out_valid) got = 1;
      else begin
        if (busy) busy_n++;
        if (toggle) begin
          a = W'($urandom); b = W'($urandom);
          cin = 1'($urandom_range(0, 1));
          in_valid = 1'($urandom_range(0, 1));
        end
      end
    end
    in_valid = 1'b0;
    check("valid_latency", 64'(k), 64'(W + 1));
    check("busy_cycles", 64'(busy_n), 64'(W));
    check("in_ready_done", 64'(in_ready), 64'd0);
    held_sum = sum; held_cout = cout;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      a = W'($urandom); b = W'($urandom);
      @(negedge clk);
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_sum", 64'({cout, sum}), 64'({held_cout, held_sum}));
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    if (exp_q.size() > 0) check("result", 64'({cout, sum}), 64'(exp_q.pop_front()));
`ifdef SERIAL_ADD_OVF_EN
    if (ovf_q.size() > 0) check("ovf", 64'(ovf), 64'(ovf_q.pop_front()));
`else
    if (ovf_q.size() > 0) void'(ovf_q.pop_front());
`endif
    // Offer new operands on the DONE->IDLE edge; they must not be taken.
    out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_xfer", 64'(in_ready), 64'd1);
    check("no_accept_on_xfer", 64'(busy), 64'd0);
    check("valid_drop", 64'(out_valid), 64'd0);
    in_valid = 1'b0;
  endtask

  initial begin
    int k;
    checks = 0; errors = 0;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", 64'({cout, sum}), 64'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("rst_ovf", 64'(ovf), 64'd0);
`endif
    rst = 1'b0;

    run_op(8'h00, 8'h00, 1'b0, 0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 0, 0);
    run_op(8'hA5, 8'h5A, 1'b1, 0, 1);
    run_op(8'h3C, 8'h81, 1'b1, 5, 0);

    // Reset on the 4th RUN cycle: the in-flight operation is abandoned.
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    k = 0;
    while (k < 4) begin
      @(negedge clk);
      k++;
    end
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_result", 64'({cout, sum}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("no_stale_result", 64'(out_valid), 64'd0);
    end
    run_op(8'h03, 8'h04, 1'b0, 0, 0);

`ifdef SERIAL_ADD_OVF_EN
    run_op(8'h7F, 8'h01, 1'b0, 0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 0, 0);
    run_op(8'h80, 8'h80, 1'b0, 0, 0);
`endif

    for (int i = 0; i < 6; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
